// File: rtl/comparador_serial_der_izq_pkg.sv
// Shared state encoding, result flags and decode helper for the right-to-left serial comparator.
// The encodings match the left-to-right iterative network, so both read the same state codes.
package comparador_serial_der_izq_pkg;

  localparam int WIDTH_DEF = 8;

  localparam logic [1:0] EST_REPOSO = 2'b00;
  localparam logic [1:0] EST_A      = 2'b01;
  localparam logic [1:0] EST_B      = 2'b10;
  localparam logic [1:0] EST_C      = 2'b11;

  typedef enum logic [1:0] {
    REPOSO = EST_REPOSO,
    IGUAL  = EST_A,
    MAYOR  = EST_B,
    MENOR  = EST_C
  } estado_t;

  typedef struct packed {
    logic mayor;
    logic menor;
    logic igual;
  } flags_t;

  // One-hot decode of a frame-open state; REPOSO never reaches this at close time.
  function automatic flags_t decode_flags(input estado_t est);
    flags_t f;
    f = '0;
    case (est)
      IGUAL:   f.igual = 1'b1;
      MAYOR:   f.mayor = 1'b1;
      MENOR:   f.menor = 1'b1;
      default: f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/comparador_serial_der_izq_celda.sv
// Combinational next-state cell {p,q,Ai,Bi} -> {P,Q} for a right-to-left comparison step.
// A differing pair always wins because it is more significant than everything seen before.
module celda_tipica_der_izq (
  input  logic p,
  input  logic q,
  input  logic ai,
  input  logic bi,
  output logic p_next,
  output logic q_next
);

  always_comb begin
    p_next = p;
    q_next = q;
    if (ai ^ bi) begin
      // ai=1,bi=0 -> 10 (A>B); ai=0,bi=1 -> 11 (A<B)
      p_next = 1'b1;
      q_next = bi;
    end
  end

endmodule

// File: rtl/comparador_serial_der_izq.sv
// Serial magnitude comparator, one bit pair per clock, LSB first; closes on last or on the WIDTH-th pair.
// Holds the state register, pair counter, close detection and registered result/done outputs.
module comparador_serial_der_izq
  import comparador_serial_der_izq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  localparam int NW = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          valid,
  input  logic          ai,
  input  logic          bi,
  input  logic          last,
  output logic          busy,
  output logic          done,
  output logic          mayor,
  output logic          menor,
  output logic          igual,
  output logic [NW-1:0] n_bits
);

  // Input qualification: there is no ready. A pair is consumed on any rising edge where
  // valid=1 and a frame is open (or being opened by start in that same cycle); last only
  // means something together with such an accepted pair.

  estado_t       state_q, state_d;
  logic [NW-1:0] n_bits_q, n_bits_d;
  flags_t        flags_q, flags_d;
  logic          done_q, done_d;

  estado_t       base_state;
  estado_t       cell_state;
  logic          cell_p, cell_q;
  logic          frame_open;
  logic          accept;
  logic [NW-1:0] n_bits_base;
  logic [NW-1:0] n_bits_inc;
  logic          close;

  // A start in the same cycle as a pair makes that pair the first bit of a fresh frame.
  assign base_state  = start ? IGUAL : state_q;
  assign n_bits_base = start ? '0 : n_bits_q;
  assign frame_open  = start || (state_q != REPOSO);
  assign accept      = valid && frame_open;
  assign n_bits_inc  = n_bits_base + NW'(1);
  assign close       = accept && (last || (n_bits_inc == NW'(WIDTH)));

  celda_tipica_der_izq u_celda (
    .p      (base_state[1]),
    .q      (base_state[0]),
    .ai     (ai),
    .bi     (bi),
    .p_next (cell_p),
    .q_next (cell_q)
  );

  assign cell_state = estado_t'({cell_p, cell_q});

  always_comb begin
    state_d  = state_q;
    n_bits_d = n_bits_q;
    flags_d  = flags_q;
    done_d   = 1'b0;

    if (start) begin
      state_d  = IGUAL;
      n_bits_d = '0;
    end

    if (accept) begin
      state_d  = cell_state;
      n_bits_d = n_bits_inc;
      if (close) begin
        state_d = REPOSO;
        flags_d = decode_flags(cell_state);
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= REPOSO;
      n_bits_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_bits_q <= n_bits_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != REPOSO);
  assign done   = done_q;
  assign mayor  = flags_q.mayor;
  assign menor  = flags_q.menor;
  assign igual  = flags_q.igual;
  assign n_bits = n_bits_q;

endmodule

// File: tb/tb_comparador_serial_der_izq.sv
// Randomized bench for the serial right-to-left comparator with an integer-compare reference model.
// Expected results are queued at frame issue; a monitor pops and compares on every done pulse.
module tb_comparador_serial_der_izq;

  localparam int WIDTH = 8;
  localparam int NW    = $clog2(WIDTH + 1);
  localparam int EW    = 3 + NW;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          valid;
  logic          ai;
  logic          bi;
  logic          last;
  logic          busy;
  logic          done;
  logic          mayor;
  logic          menor;
  logic          igual;
  logic [NW-1:0] n_bits;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic prev_done = 1'b0;

  comparador_serial_der_izq #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .valid  (valid),
    .ai     (ai),
    .bi     (bi),
    .last   (last),
    .busy   (busy),
    .done   (done),
    .mayor  (mayor),
    .menor  (menor),
    .igual  (igual),
    .n_bits (n_bits)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: compare the low n bits as plain unsigned integers.
  function automatic logic [EW-1:0] model(input logic [7:0] a, input logic [7:0] b, input int n);
    int unsigned mask, av, bv;
    mask = (32'd1 << n) - 1;
    av = a & mask;
    bv = b & mask;
    return {av > bv, av < bv, av == bv, NW'(n)};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (prev_done) chk("done_width", 1, 0);
        if (exp_q.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          chk("result", {mayor, menor, igual, n_bits}, exp_q.pop_front());
          chk("busy_at_done", busy, 0);
        end
      end
      prev_done <= done;
    end else begin
      prev_done <= 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    start = 1'b0;
    valid = 1'b0;
    last  = 1'b0;
    ai    = 1'($urandom_range(0, 1));
    bi    = 1'($urandom_range(0, 1));
  endtask

  task automatic open_frame();
    idle();
    start = 1'b1;
    last  = 1'($urandom_range(0, 1));
    cyc();
    idle();
  endtask

  // Pairs without last, used for frames that get aborted or reset.
  task automatic send_pairs(input logic [7:0] a, input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      idle();
      valid = 1'b1;
      ai = a[i];
      bi = b[i];
      cyc();
    end
    idle();
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input int n,
                            input bit use_last, input bit merge, input bit gaps);
    exp_q.push_back(model(a, b, n));
    if (!merge) open_frame();
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        idle();
        last = 1'($urandom_range(0, 1));
        cyc();
      end
      idle();
      valid = 1'b1;
      ai    = a[i];
      bi    = b[i];
      last  = use_last && (i == n - 1);
      start = merge && (i == 0);
      cyc();
    end
    idle();
    chk("done_latency", done, 1);
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    logic [7:0] ra, rb;
    int n;
    bit use_last;
    rst_n = 1'b0;
    idle();
    repeat (3) cyc();
    chk("reset_state", {busy, done, mayor, menor, igual, n_bits}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Equal words, full frame with last on pair 8.
    send_frame(8'h5A, 8'h5A, 8, 1, 0, 0);
    cyc();
    // MSB difference overrides the LSB decision.
    send_frame(8'h80, 8'h7F, 8, 1, 0, 0);
    cyc();
    // Auto-close on the WIDTH-th pair without last.
    send_frame(8'h01, 8'h02, 8, 0, 0, 0);
    cyc();

    // Reset mid-frame after 3 pairs: everything clears immediately, no done.
    open_frame();
    send_pairs(8'hF0, 8'h0F, 3);
    chk("mid_nbits", n_bits, 3);
    chk("mid_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {busy, done, mayor, menor, igual, n_bits}, 0);
    repeat (2) cyc();
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Abort after 4 pairs, then a 2-bit frame of equal words.
    open_frame();
    send_pairs(8'h0F, 8'h03, 4);
    chk("abort_no_done", done, 0);
    send_frame(8'h03, 8'h03, 2, 1, 0, 0);
    cyc();

    // 1-bit frame via start&valid&last, then valid pulses while idle.
    send_frame(8'h01, 8'h00, 1, 1, 1, 0);
    repeat (3) begin
      idle();
      valid = 1'b1;
      last  = 1'($urandom_range(0, 1));
      cyc();
    end
    idle();
    cyc();
    chk("idle_valid_flags", {mayor, menor, igual}, 3'b100);
    chk("idle_valid_nbits", n_bits, 1);
    chk("idle_valid_busy", busy, 0);

    // Randomized frames, with occasional aborts, gaps and merged starts.
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        open_frame();
        send_pairs(8'($urandom), 8'($urandom), $urandom_range(1, WIDTH - 1));
      end
      ra = 8'($urandom);
      rb = ($urandom_range(0, 2) == 0) ? ra : 8'($urandom);
      n = $urandom_range(1, WIDTH);
      use_last = (n < WIDTH) ? 1'b1 : 1'($urandom_range(0, 1));
      send_frame(ra, rb, n, use_last, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) cyc();
    end

    // Bounded drain of the expected queue.
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) cyc();
    chk("queue_drained", exp_q.size(), 0);
    repeat (2) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
